// File: rtl/chart_pkg.sv
`default_nettype none
// ==== chart_pkg | chart entry layout, end marker and sequencer states | rev 1.0 ====
package chart_pkg;
   localparam int TIME_MSB = 31;
   localparam int TIME_LSB = 12;
   localparam int LANE_MSB = 11;
   localparam int LANE_LSB = 8;
   localparam logic [19:0] END_TIME = 20'hFFFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_CHECK = 3'd3,
      ST_EMIT  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;
endpackage
`default_nettype wire

// File: rtl/chart_sequencer_ms_tick.sv
`default_nettype none
// ==== ms_tick | song-clock prescaler, one-cycle tick on each wrap | rev 1.0 ====
module ms_tick #(
   parameter int DIV = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

   logic [CW-1:0] count_q, count_d;

   // clr beats a simultaneous wrap, so a restart never produces a stray tick
   always_comb begin
      count_d = count_q;
      tick    = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         if (count_q == C_LAST) begin
            count_d = '0;
            tick    = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end
endmodule
`default_nettype wire

// File: rtl/chart_sequencer.sv
`default_nettype none
// ==== chart_sequencer | song clock + chart ROM walker, releases notes LEAD_MS early | rev 1.0 ====
module chart_sequencer
   import chart_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000,
   parameter int LEAD_MS = 1000,
   parameter int ADDR_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic [3:0]        music_id,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic              note_valid,
   input  logic              note_ready,
   output logic [3:0]        note_lanes,
   output logic [19:0]       note_time,
   output logic [19:0]       song_ms,
   output logic              playing,
   output logic              done
);
   localparam int SLOT_W = ADDR_W - 4;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [19:0]       ent_time_q, ent_time_d;
   logic [3:0]        ent_lanes_q, ent_lanes_d;
   logic              valid_q, valid_d;
   logic [3:0]        lanes_q, lanes_d;
   logic [19:0]       time_q, time_d;
   logic [19:0]       ms_q, ms_d;
   logic              playing_q, playing_d;
   logic              done_q, done_d;

   logic tick;
   logic due;
   logic last_slot;
   logic unused_rsvd;

   ms_tick #(.DIV(CLK_HZ / TICK_HZ)) u_ms_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (start),
      .en   (playing_q && !pause),
      .tick (tick)
   );

   assign unused_rsvd = ^rom_data[7:0];
   // 21-bit sum so a late chart near the top of the ms range cannot wrap
   assign due       = ({1'b0, ms_q} + 21'(LEAD_MS)) >= {1'b0, ent_time_q};
   assign last_slot = &addr_q[SLOT_W-1:0];

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ent_time_d  = ent_time_q;
      ent_lanes_d = ent_lanes_q;
      valid_d     = valid_q;
      lanes_d     = lanes_q;
      time_d      = time_q;
      done_d      = done_q;
      ms_d        = ms_q;

      if (tick && ms_q != END_TIME) ms_d = ms_q + 20'd1;

      case (state_q)
         ST_IDLE: ;
         ST_FETCH: state_d = ST_LATCH;
         ST_LATCH: begin
            ent_time_d  = rom_data[TIME_MSB:TIME_LSB];
            ent_lanes_d = rom_data[LANE_MSB:LANE_LSB];
            state_d     = ST_CHECK;
         end
         ST_CHECK: begin
            if (ent_lanes_q == 4'd0) begin
               if (ent_time_q == END_TIME || last_slot) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_FETCH;
               end
            end else if (due) begin
               valid_d = 1'b1;
               lanes_d = ent_lanes_q;
               time_d  = ent_time_q;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (note_ready) begin
               valid_d = 1'b0;
               if (last_slot) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_FETCH;
               end
            end
         end
         ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase

      // restart from any state, abandoning a pending note
      if (start) begin
         state_d = ST_FETCH;
         addr_d  = {music_id, {SLOT_W{1'b0}}};
         valid_d = 1'b0;
         done_d  = 1'b0;
         ms_d    = '0;
      end

      playing_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         ent_time_q  <= '0;
         ent_lanes_q <= '0;
         valid_q     <= 1'b0;
         lanes_q     <= '0;
         time_q      <= '0;
         ms_q        <= '0;
         playing_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ent_time_q  <= ent_time_d;
         ent_lanes_q <= ent_lanes_d;
         valid_q     <= valid_d;
         lanes_q     <= lanes_d;
         time_q      <= time_d;
         ms_q        <= ms_d;
         playing_q   <= playing_d;
         done_q      <= done_d;
      end
   end

   assign rom_addr   = addr_q;
   assign note_valid = valid_q;
   assign note_lanes = lanes_q;
   assign note_time  = time_q;
   assign song_ms    = ms_q;
   assign playing    = playing_q;
   assign done       = done_q;
endmodule
`default_nettype wire

// File: tb/tb_chart_sequencer.sv
`default_nettype none
// ==== tb_chart_sequencer | scoreboard bench: chart model vs. released notes | rev 1.0 ====
module tb_chart_sequencer;
   localparam int CLK_HZ = 10;
   localparam int TICK_HZ = 1;
   localparam int LEAD = 1000;
   localparam int ADDR_W = 12;
   localparam int CPM = CLK_HZ / TICK_HZ;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, note_ready = 1'b0;
   logic [3:0] music_id = 4'd0;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0] rom_data;
   logic note_valid, playing, done;
   logic [3:0] note_lanes;
   logic [19:0] note_time, song_ms;

   chart_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LEAD_MS(LEAD), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .music_id(music_id),
      .rom_addr(rom_addr), .rom_data(rom_data), .note_valid(note_valid),
      .note_ready(note_ready), .note_lanes(note_lanes), .note_time(note_time),
      .song_ms(song_ms), .playing(playing), .done(done));

   always #5 clk = ~clk;

   logic [31:0] rom [0:4095];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int n_checks = 0, n_fail = 0, cyc = 0, n_xfer = 0;
   logic [23:0] exp_q[$];
   int xfer_cyc[$];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ent(input int t, input int m);
      logic [31:0] r;
      r = $urandom;
      return {t[19:0], m[3:0], r[7:0]};
   endfunction

   // Expected note list for a song: walk its slot in order, drop blank entries,
   // stop at the end marker or the end of the slot.
   task automatic build_expected(input logic [3:0] id);
      for (int i = 0; i < 256; i++) begin
         logic [31:0] e;
         e = rom[{id, 8'(i)}];
         if (e[11:8] == 4'd0 && e[31:12] == 20'hFFFFF) break;
         if (e[11:8] != 4'd0) exp_q.push_back({e[11:8], e[31:12]});
      end
   endtask

   task automatic do_start(input logic [3:0] id);
      exp_q.delete();
      build_expected(id);
      music_id = id;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int max);
      int i;
      for (i = 0; i < max; i++) begin
         if (note_valid) break;
         @(posedge clk); #1;
      end
      check({name, "_valid_timeout"}, note_valid, 1);
   endtask

   task automatic wait_done(input string name, input int max, input bit rnd);
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (rnd) note_ready = 1'($urandom_range(0, 1));
         if (done) break;
      end
      check({name, "_done"}, done, 1);
      check({name, "_all_delivered"}, exp_q.size(), 0);
   endtask

   // Monitor: releases, handshake stability and ordered delivery
   logic prev_valid = 1'b0, prev_taken = 1'b0;
   logic [3:0] prev_lanes = 4'd0;
   logic [19:0] prev_time = 20'd0;
   always @(negedge clk) begin : mon
      logic taken;
      logic [23:0] got;
      if (rst) begin
         prev_valid = 1'b0;
         prev_taken = 1'b0;
      end else begin
         got = {note_lanes, note_time};
         if (prev_taken) check("valid_falls_after_xfer", note_valid, 0);
         if (note_valid && prev_valid && !prev_taken) begin
            check("hold_lanes", note_lanes, prev_lanes);
            check("hold_time", note_time, prev_time);
         end
         if (note_valid && (!prev_valid || prev_taken)) begin
            check("release_not_early", ({1'b0, song_ms} + 21'(LEAD)) >= {1'b0, note_time}, 1);
            check("note_expected", exp_q.size() > 0, 1);
         end
         taken = note_valid && note_ready;
         if (taken) begin
            check("xfer_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("xfer_note", got, exp_q.pop_front());
            xfer_cyc.push_back(cyc);
            n_xfer++;
         end
         prev_valid = note_valid;
         prev_taken = taken;
         prev_lanes = note_lanes;
         prev_time  = note_time;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish, n_fail %0d", n_fail);
      $fatal(1, "global timeout");
   end

   initial begin
      int x0, ms0, k, t;
      for (int i = 0; i < 4096; i++) rom[i] = {20'hFFFFF, 4'h0, 8'h00};

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_addr", rom_addr, 0);
      check("rst_valid", note_valid, 0);
      check("rst_playing", playing, 0);
      check("rst_done", done, 0);
      check("rst_song_ms", song_ms, 0);

      // Reset in the middle of EMIT
      rom[12'h300] = ent(0, 15);
      do_start(4'd3);
      wait_valid("rstemit", 50);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst2_out", {rom_addr, note_valid, note_lanes, note_time, song_ms, playing, done}, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("rst2_idle", {note_valid, playing}, 0);
      end

      // Basic release and backpressure
      rom[12'h200] = ent(1500, 4'b0101);
      do_start(4'd2);
      check("basic_addr", rom_addr, 12'h200);
      check("basic_playing", playing, 1);
      wait_valid("basic", 6000);
      check("basic_rise_ms", song_ms, 500);
      check("basic_lanes", note_lanes, 4'b0101);
      check("basic_time", note_time, 1500);
      ms0 = int'(song_ms);
      x0 = n_xfer;
      repeat (20) @(posedge clk);
      #1;
      check("bp_valid_high", note_valid, 1);
      check("bp_ms_advance", song_ms, ms0 + 2);
      check("bp_xfers_none", n_xfer - x0, 0);
      note_ready = 1'b1;
      wait_done("basic", 40, 0);
      check("bp_one_xfer", n_xfer - x0, 1);

      // Burst of due notes with ready held high
      rom[12'h500] = ent(0, 1);
      rom[12'h501] = ent(0, 2);
      rom[12'h502] = ent(0, 4);
      x0 = n_xfer;
      do_start(4'd5);
      wait_done("burst", 100, 0);
      check("burst_count", n_xfer - x0, 3);
      if (xfer_cyc.size() >= 3) begin
         check("burst_gap1", xfer_cyc[xfer_cyc.size()-2] - xfer_cyc[xfer_cyc.size()-3], 4);
         check("burst_gap2", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[xfer_cyc.size()-2], 4);
      end

      // Pause freezes song clock and prescaler
      rom[12'h600] = ent(2000, 3);
      note_ready = 1'b0;
      do_start(4'd6);
      ms0 = int'(song_ms);
      for (int i = 0; i < 3 * CPM && int'(song_ms) == ms0; i++) begin
         @(posedge clk); #1;
      end
      check("pause_pre_tick", song_ms, ms0 + 1);
      repeat (3) @(posedge clk);
      #1 pause = 1'b1;
      ms0 = int'(song_ms);
      repeat (50) @(posedge clk);
      #1;
      check("pause_frozen", song_ms, ms0);
      pause = 1'b0;
      k = 0;
      for (int i = 0; i < 3 * CPM; i++) begin
         @(posedge clk); #1;
         k++;
         if (int'(song_ms) != ms0) break;
      end
      check("pause_resume_cycles", k, CPM - 3);
      check("pause_resume_ms", song_ms, ms0 + 1);

      // Restart mid-play, skip entry, single emit, end marker
      rom[12'h700] = ent(7, 0);
      rom[12'h701] = ent(9, 4'b1000);
      note_ready = 1'b1;
      x0 = n_xfer;
      do_start(4'd7);
      check("restart_ms", song_ms, 0);
      check("restart_addr", rom_addr, 12'h700);
      check("restart_done", done, 0);
      wait_done("end", 100, 0);
      check("end_one_emit", n_xfer - x0, 1);
      ms0 = int'(song_ms);
      repeat (3 * CPM) @(posedge clk);
      #1;
      check("done_holds", done, 1);
      check("done_ms_runs", song_ms, ms0 + 3);
      do_start(4'd7);
      check("redo_done_clr", done, 0);
      check("redo_ms", song_ms, 0);
      check("redo_addr", rom_addr, 12'h700);
      wait_done("redo", 100, 0);

      // Full slot without end marker: no wrap past the last entry
      for (int i = 0; i < 256; i++)
         rom[12'hF00 + i] = ent($urandom_range(0, 1000), $urandom_range(1, 15));
      x0 = n_xfer;
      do_start(4'd15);
      wait_done("slot", 5000, 1);
      check("slot_count", n_xfer - x0, 256);
      check("slot_no_wrap", rom_addr, 12'hFFF);

      // Random charts with skips, waits and random backpressure
      for (int s = 8; s < 12; s++) begin
         t = 990;
         for (int i = 0; i < 20; i++) begin
            t += $urandom_range(0, 3);
            rom[{4'(s), 8'(i)}] = ent(t, (i % 7 == 3) ? 0 : $urandom_range(1, 15));
         end
         rom[{4'(s), 8'd20}] = ent(20'hFFFFF, 0);
         do_start(4'(s));
         wait_done("rand", 3000, 1);
      end

      note_ready = 1'b0;
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
